// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and opcode-class helpers for seq_alu.
// Defining SEQ_ALU_SIGNED_EN adds the signed MULS/DIVS opcodes.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIVU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_CLO  = 4'd7;
  localparam logic [3:0] OP_CLZ  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_ROTL = 4'd12;
  localparam logic [3:0] OP_MULS = 4'd13;
  localparam logic [3:0] OP_DIVS = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  function automatic logic op_is_mul(input logic [3:0] op);
`ifdef SEQ_ALU_SIGNED_EN
    return (op == OP_MUL) || (op == OP_MULS);
`else
    return (op == OP_MUL);
`endif
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
`ifdef SEQ_ALU_SIGNED_EN
    return (op == OP_DIVU) || (op == OP_DIVS);
`else
    return (op == OP_DIVU);
`endif
  endfunction

  function automatic logic op_is_multicycle(input logic [3:0] op);
    return op_is_mul(op) || op_is_div(op);
  endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
// done is high during the final iteration, so quotient/remainder are final the cycle after.
module seq_alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   trial;

  assign done      = run_q && (cnt_q == '1);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    trial = {rem_q, quo_q[WIDTH-1]};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = WIDTH'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + SHW'(1);
      if (done) run_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops, iterative shift-add multiply and restoring divide.
// Defining SEQ_ALU_SIGNED_EN adds signed MULS (op 13) and DIVS (op 14).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             output_inverted,
  input  logic             output_inc,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] res_high,
  output logic [WIDTH-1:0] res_low
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] res_high_q, res_high_d, res_low_q, res_low_d;
  logic             inv_q, inv_d, inc_q, inc_d, done_q, done_d, dbz_q, dbz_d;

  logic             div_start, div_done;
  logic [WIDTH-1:0] div_a, div_b, div_quo, div_rem, mul_b_init, mcand;
  logic [WIDTH:0]   mul_sum, sum;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     lead;
  logic             lead_stop;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [2*WIDTH-1:0] r_post;

`ifdef SEQ_ALU_SIGNED_EN
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
`endif

  // Operand conditioning: signed ops run the unsigned engines on magnitudes.
  always_comb begin
    mul_b_init = b;
    div_a      = a;
    div_b      = b;
    mcand      = a_q;
`ifdef SEQ_ALU_SIGNED_EN
    if (aluop == OP_MULS) mul_b_init = mag(b);
    if (aluop == OP_DIVS) begin
      div_a = mag(a);
      div_b = mag(b);
    end
    if (op_q == OP_MULS) mcand = mag(a_q);
`endif
  end

  assign div_start = (state_q == S_IDLE) && start && op_is_div(aluop) && (b != '0);
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, mcand & {WIDTH{acc_lo_q[0]}}};

  seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_a),
    .divisor   (div_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Raw 2*WIDTH result from the latched operands; only consumed in FIN.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    sh        = b_q[SHW-1:0];
    lead      = '0;
    lead_stop = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!lead_stop && (a_q[i] == (op_q == OP_CLO))) lead = lead + (SHW+1)'(1);
      else lead_stop = 1'b1;
    end
    r_hi = '0;
    r_lo = '0;
    case (op_q)
      OP_ADD: begin
        r_lo = sum[WIDTH-1:0];
        r_hi = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      end
      OP_SUB: begin
        r_lo = a_q - b_q;
        r_hi = (a_q < b_q) ? '1 : '0;
      end
      OP_MUL: {r_hi, r_lo} = {acc_hi_q, acc_lo_q};
      OP_DIVU: begin
        r_hi = (b_q == '0) ? a_q : div_rem;
        r_lo = (b_q == '0) ? '1  : div_quo;
      end
      OP_AND:  r_lo = a_q & b_q;
      OP_OR:   r_lo = a_q | b_q;
      OP_XOR:  r_lo = a_q ^ b_q;
      OP_CLO, OP_CLZ: r_lo = WIDTH'(lead);
      OP_SLL:  r_lo = a_q << sh;
      OP_SRL:  r_lo = a_q >> sh;
      OP_SRA: begin
        r_lo = $signed(a_q) >>> sh;
        r_hi = {WIDTH{a_q[WIDTH-1]}};
      end
      // a >> (WIDTH-sh) written as (a >> 1) >> ~sh so sh=0 needs no special case.
      OP_ROTL: r_lo = (a_q << sh) | ((a_q >> 1) >> ~sh);
`ifdef SEQ_ALU_SIGNED_EN
      OP_MULS: {r_hi, r_lo} = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -{acc_hi_q, acc_lo_q}
                                                            :  {acc_hi_q, acc_lo_q};
      OP_DIVS: begin
        if (b_q == '0) begin
          r_hi = a_q;
          r_lo = '1;
        end else begin
          r_lo = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -div_quo : div_quo;
          r_hi = a_q[WIDTH-1] ? -div_rem : div_rem;
        end
      end
`endif
      default: ;
    endcase
    r_post = (inv_q ? ~{r_hi, r_lo} : {r_hi, r_lo}) + {{(2*WIDTH-1){1'b0}}, inc_q};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    inv_d      = inv_q;
    inc_d      = inc_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    res_high_d = res_high_q;
    res_low_d  = res_low_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = aluop;
          a_d      = a;
          b_d      = b;
          inv_d    = output_inverted;
          inc_d    = output_inc;
          dbz_d    = 1'b0;
          acc_hi_d = '0;
          acc_lo_d = mul_b_init;
          cnt_d    = '0;
          if (op_is_mul(aluop))           state_d = S_MUL;
          else if (div_start)             state_d = S_DIV;
          else                            state_d = S_FIN;
        end
      end
      S_MUL: begin
        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == '1) state_d = S_FIN;
      end
      S_DIV: begin
        if (div_done) state_d = S_FIN;
      end
      S_FIN: begin
        {res_high_d, res_low_d} = r_post;
        done_d  = 1'b1;
        dbz_d   = op_is_div(op_q) && (b_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      inv_q      <= 1'b0;
      inc_q      <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      res_high_q <= '0;
      res_low_q  <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      inv_q      <= inv_d;
      inc_q      <= inc_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      res_high_q <= res_high_d;
      res_low_q  <= res_low_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign res_high    = res_high_q;
  assign res_low     = res_low_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// A negedge compare process checks busy/done/results every cycle; directed cases pin literals.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  aluop = '0;
  logic [31:0] a = '0, b = '0;
  logic        inv = 1'b0, inc = 1'b0;
  logic        busy, done, dbz;
  logic [31:0] res_high, res_low;

  logic        start8 = 1'b0;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        zero8 = 1'b0;
  logic        busy8, done8, dbz8;
  logic [7:0]  rh8, rl8;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .a(a), .b(b),
    .output_inverted(inv), .output_inc(inc), .busy(busy), .done(done),
    .div_by_zero(dbz), .res_high(res_high), .res_low(res_low)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .aluop(op8), .a(a8), .b(b8),
    .output_inverted(zero8), .output_inc(zero8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .res_high(rh8), .res_low(rl8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: returns {div_by_zero, res_high, res_low}.
  function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] x, y,
                                        input logic iv, ic);
    logic [63:0] r;
    logic [31:0] t;
    logic        dz;
    int          n, s;
    r = '0; dz = 1'b0; n = 0; s = int'(y[4:0]);
    case (op)
      4'd0: r = {32'd0, x} + {32'd0, y};
      4'd1: r = {(x < y) ? 32'hFFFF_FFFF : 32'h0, x - y};
      4'd2: r = {32'd0, x} * {32'd0, y};
      4'd3: if (y == 0) begin r = {x, 32'hFFFF_FFFF}; dz = 1'b1; end
            else r = {x % y, x / y};
      4'd4: r = {32'd0, x & y};
      4'd5: r = {32'd0, x | y};
      4'd6: r = {32'd0, x ^ y};
      4'd7: begin while (n < 32 && x[31-n])  n++; r = 64'(n); end
      4'd8: begin while (n < 32 && !x[31-n]) n++; r = 64'(n); end
      4'd9:  begin t = x << s; r = {32'd0, t}; end
      4'd10: begin t = x >> s; r = {32'd0, t}; end
      4'd11: begin t = $signed(x) >>> s; r = {{32{x[31]}}, t}; end
      4'd12: begin t = (x << s) | (x >> (32 - s)); r = {32'd0, t}; end
`ifdef SEQ_ALU_SIGNED_EN
      4'd13: begin
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        r = 64'(p);
      end
      4'd14: begin
        if (y == 0) begin r = {x, 32'hFFFF_FFFF}; dz = 1'b1; end
        else begin
          longint q, m;
          q = longint'($signed(x)) / longint'($signed(y));
          m = longint'($signed(x)) % longint'($signed(y));
          r = {m[31:0], q[31:0]};
        end
      end
`endif
      default: r = '0;
    endcase
    r = (iv ? ~r : r) + 64'(ic);
    return {dz, r};
  endfunction

  function automatic int lat(input logic [3:0] op, input logic [31:0] y);
    bit mc;
    mc = (op == 4'd2) || (op == 4'd3 && y != 0);
`ifdef SEQ_ALU_SIGNED_EN
    mc = mc || (op == 4'd13) || (op == 4'd14 && y != 0);
`endif
    return mc ? 33 : 1;
  endfunction

  // Scoreboard state: after rising edge k, cyc == k.
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          pending = 1'b0;
  int          s_cyc = 0, d_cyc = 0;
  logic [63:0] exp_res = '0, held_res = '0;
  logic        exp_dbz = 1'b0, held_dbz = 1'b0;
  logic        eb, ed;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      eb = pending && cyc >= s_cyc && cyc < d_cyc;
      ed = pending && cyc == d_cyc;
      if (pending && cyc == s_cyc) held_dbz = 1'b0;
      if (ed) begin
        held_res = exp_res;
        held_dbz = exp_dbz;
        pending  = 1'b0;
      end
      check("busy", 64'(busy), 64'(eb));
      check("done", 64'(done), 64'(ed));
      check("res_high", 64'(res_high), 64'(held_res[63:32]));
      check("res_low", 64'(res_low), 64'(held_res[31:0]));
      check("div_by_zero", 64'(dbz), 64'(held_dbz));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] av, bv, input logic iv, ic);
    logic [64:0] m;
    @(posedge clk); #1;
    start = 1'b1; aluop = op; a = av; b = bv; inv = iv; inc = ic;
    m       = model(op, av, bv, iv, ic);
    exp_res = m[63:0];
    exp_dbz = m[64];
    s_cyc   = cyc + 1;
    d_cyc   = s_cyc + lat(op, bv);
    pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] av, bv,
                        input logic iv, ic, input bit glitch);
    issue(op, av, bv, iv, ic);
    if (glitch) begin
      start = 1'b1; aluop = 4'($urandom); a = $urandom; b = $urandom;
      inv = 1'($urandom); inc = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int g = 0; g < 100 && cyc < d_cyc; g++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [3:0]  op;
    logic [31:0] av, bv;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_dbz", 64'(dbz), 64'h0);
    check("rst_high", 64'(res_high), 64'h0);
    check("rst_low", 64'(res_low), 64'h0);
    rst = 1'b1;
    chk_en = 1'b1;

    // 8-bit instance: MUL FF*FF completes 9 edges after the start edge.
    @(posedge clk); #1;
    start8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_mul_latency", 64'(n), 64'd9);
    check("w8_mul_high", 64'(rh8), 64'hFE);
    check("w8_mul_low", 64'(rl8), 64'h01);

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    check("add_low", 64'(res_low), 64'h0);
    check("add_high", 64'(res_high), 64'h1);
    run_op(OP_SUB, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    check("sub_low", 64'(res_low), 64'hFFFF_FFFE);
    check("sub_high", 64'(res_high), 64'hFFFF_FFFF);
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    check("mul_high", 64'(res_high), 64'hFFFF_FFFE);
    check("mul_low", 64'(res_low), 64'h1);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
    check("divu_rem", 64'(res_high), 64'd2);
    check("divu_quo", 64'(res_low), 64'd14);
    check("divu_dbz", 64'(dbz), 64'h0);
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    check("div0_low", 64'(res_low), 64'hFFFF_FFFF);
    check("div0_high", 64'(res_high), 64'd5);
    check("div0_dbz", 64'(dbz), 64'h1);
    run_op(OP_CLO, 32'hF000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    check("clo_low", 64'(res_low), 64'd4);
    run_op(OP_CLZ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("clz_low", 64'(res_low), 64'd32);
    run_op(OP_SRA, 32'h8000_0000, 32'd31, 1'b0, 1'b0, 1'b0);
    check("sra_low", 64'(res_low), 64'hFFFF_FFFF);
    check("sra_high", 64'(res_high), 64'hFFFF_FFFF);
    run_op(OP_AND, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("wrap_result", {32'(res_high), 32'(res_low)}, 64'h0);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      av = pick();
      bv = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      run_op(op, av, bv, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a divide.
    run_op(OP_ADD, 32'h1234, 32'h1, 1'b0, 1'b0, 1'b0);
    issue(OP_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("pre_abort_busy", 64'(busy), 64'h1);
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_dbz", 64'(dbz), 64'h0);
    check("abort_high", 64'(res_high), 64'h0);
    check("abort_low", 64'(res_low), 64'h0);
    pending  = 1'b0;
    held_res = '0;
    held_dbz = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1'b1;
    run_op(OP_ADD, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    check("post_abort_add", 64'(res_low), 64'd5);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
